wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 28 ++
 rtl/pcreg.sv | 58 +++++
 rtl/wb_regfile.sv | 95 +++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared processor constants for the writeback/register-file
//               slice: data width, register index width, the PC slot index
//               and the next-PC source encoding used by pcreg.
// Revision    : 1.0  initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    // The PC occupies the highest register index.
    function automatic int pc_idx_of(input int idx_w);
        return (1 << idx_w) - 1;
    endfunction

    localparam int PC_IDX = pc_idx_of(IDX_W);

    typedef enum logic [1:0] {
        PC_SRC_HOLD = 2'd0,
        PC_SRC_SEQ  = 2'd1,
        PC_SRC_LOAD = 2'd2
    } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pcreg.sv
`default_nettype none
// ============================================================================
// Module      : pcreg
// Description : Program counter register with its priority next-PC mux.
//               Priority: branch load > sequential advance > hold (stall).
//               Synchronous active-low reset clears the PC to zero.
// Ports       : clk, rst      clock / sync active-low reset
//               i_load        load i_target (overrides stall)
//               i_stall       hold the PC when not loading
//               i_target [N]  redirect target
//               i_seq    [N]  sequential next PC
//               o_pc     [N]  current PC
// Revision    : 1.0  initial release
// ============================================================================
module pcreg
    import wb_regfile_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_stall,
    input  logic [N-1:0] i_target,
    input  logic [N-1:0] i_seq,
    output logic [N-1:0] o_pc
);

    pc_src_e      w_src;
    logic [N-1:0] r_pc;

    // A redirect is never lost: load wins even while stalled.
    always_comb begin
        if (i_load) begin
            w_src = PC_SRC_LOAD;
        end else if (!i_stall) begin
            w_src = PC_SRC_SEQ;
        end else begin
            w_src = PC_SRC_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= '0;
        end else begin
            case (w_src)
                PC_SRC_LOAD: r_pc <= i_target;
                PC_SRC_SEQ:  r_pc <= i_seq;
                default:     r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage and register file. Selects the writeback
//               result, writes general registers, owns the PC (via pcreg),
//               and serves two combinational read ports with write-through
//               bypass. Index 2^M-1 reads the PC and is never written as a
//               general register.
// Ports       : clk, rst                  clock / sync active-low reset
//               pcload_W, regw_W, regmem_W writeback controls
//               regScr_W  [M]             destination index
//               ALUrslt_W, memData_W [N]  writeback sources
//               pc_next [N], stall        sequential PC and PC hold
//               ra1, ra2 [M] -> rd1, rd2 [N]  read ports
//               pc [N], wbData [N]        current PC, selected result
// Revision    : 1.0  initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int M = IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pcload_W,
    input  logic         regw_W,
    input  logic         regmem_W,
    input  logic [M-1:0] regScr_W,
    input  logic [N-1:0] ALUrslt_W,
    input  logic [N-1:0] memData_W,
    input  logic [N-1:0] pc_next,
    input  logic         stall,
    input  logic [M-1:0] ra1,
    input  logic [M-1:0] ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    output logic [N-1:0] pc,
    output logic [N-1:0] wbData
);

    localparam int           c_NUM_GPR = pc_idx_of(M);
    localparam logic [M-1:0] c_PC_IDX  = M'(pc_idx_of(M));

    logic [N-1:0] r_regs [0:c_NUM_GPR-1];
    logic [N-1:0] w_view [0:(2**M)-1];
    logic [N-1:0] w_pc;
    logic         w_byp1;
    logic         w_byp2;

    assign wbData = regmem_W ? memData_W : ALUrslt_W;

    // General registers. The loop never reaches the PC index, so a write
    // aimed at the PC slot falls through and is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NUM_GPR; i++) begin
            if (!rst) begin
                r_regs[i] <= '0;
            end else if (regw_W && (regScr_W == M'(i))) begin
                r_regs[i] <= wbData;
            end
        end
    end

    pcreg #(
        .N (N)
    ) u_pcreg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (pcload_W),
        .i_stall  (stall),
        .i_target (wbData),
        .i_seq    (pc_next),
        .o_pc     (w_pc)
    );

    assign pc = w_pc;

    // Full index space as seen by the read ports: GPRs plus the PC slot.
    always_comb begin
        for (int i = 0; i < c_NUM_GPR; i++) begin
            w_view[i] = r_regs[i];
        end
        w_view[c_PC_IDX] = w_pc;
    end

    // Same-cycle write-through; the PC slot is never bypassed.
    assign w_byp1 = regw_W && (regScr_W == ra1) && (ra1 != c_PC_IDX);
    assign w_byp2 = regw_W && (regScr_W == ra2) && (ra2 != c_PC_IDX);

    assign rd1 = w_byp1 ? wbData : w_view[ra1];
    assign rd2 = w_byp2 ? wbData : w_view[ra2];

endmodule
`default_nettype wire
